id_ex_stage_reg: RTL

ID/EX pipeline register for the 5-stage 32-bit ARM core. It sits directly downstream of the decode control unit and register file, and captures the decoded control word and operands each cycle for the EX stage. It implements freeze (memory stall), flush (taken branch) and hazard-bubble insertion. It also keeps saturating issue/bubble counters for debug.

---
 rtl/id_ex_stage_reg_if.sv | 69 ++++++
 rtl/id_ex_stage_reg.sv | 117 +++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg_if.sv
// Decode-to-execute bundle for the ID/EX pipeline register: pipeline controls,
// decoded inputs, their registered copies and the debug counters.
interface id_ex_stage_reg_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             freeze;
  logic             flush;
  logic             hazard;

  logic             WB_EN_in;
  logic             MEM_R_EN_in;
  logic             MEM_W_EN_in;
  logic             B_in;
  logic             S_in;
  logic             move_in;
  logic [3:0]       EXE_CMD_in;
  logic [WIDTH-1:0] PC_in;
  logic [WIDTH-1:0] Val_Rn_in;
  logic [WIDTH-1:0] Val_Rm_in;
  logic             imm_in;
  logic [11:0]      Shift_operand_in;
  logic [23:0]      Signed_imm_24_in;
  logic [3:0]       Dest_in;
  logic [3:0]       src1_in;
  logic [3:0]       src2_in;
  logic [3:0]       SR_in;

  logic             WB_EN_out;
  logic             MEM_R_EN_out;
  logic             MEM_W_EN_out;
  logic             B_out;
  logic             S_out;
  logic             move_out;
  logic [3:0]       EXE_CMD_out;
  logic [WIDTH-1:0] PC_out;
  logic [WIDTH-1:0] Val_Rn_out;
  logic [WIDTH-1:0] Val_Rm_out;
  logic             imm_out;
  logic [11:0]      Shift_operand_out;
  logic [23:0]      Signed_imm_24_out;
  logic [3:0]       Dest_out;
  logic [3:0]       src1_out;
  logic [3:0]       src2_out;
  logic [3:0]       SR_out;
  logic             valid_out;
  logic [CNT_W-1:0] issued_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output freeze, flush, hazard,
    output WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, move_in, EXE_CMD_in,
    output PC_in, Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in, Signed_imm_24_in,
    output Dest_in, src1_in, src2_in, SR_in,
    input  WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, move_out, EXE_CMD_out,
    input  PC_out, Val_Rn_out, Val_Rm_out, imm_out, Shift_operand_out, Signed_imm_24_out,
    input  Dest_out, src1_out, src2_out, SR_out, valid_out, issued_cnt, bubble_cnt
  );

  modport slave (
    input  freeze, flush, hazard,
    input  WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, move_in, EXE_CMD_in,
    input  PC_in, Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in, Signed_imm_24_in,
    input  Dest_in, src1_in, src2_in, SR_in,
    output WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, move_out, EXE_CMD_out,
    output PC_out, Val_Rn_out, Val_Rm_out, imm_out, Shift_operand_out, Signed_imm_24_out,
    output Dest_out, src1_out, src2_out, SR_out, valid_out, issued_cnt, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with freeze, flush/hazard bubble insertion and
// saturating issue/bubble debug counters.
module id_ex_stage_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  id_ex_stage_reg_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             bubble_s;
  logic             mem_w_en_s;
  logic [CNT_W-1:0] issued_next_s;
  logic [CNT_W-1:0] bubble_next_s;

  logic             wb_en_r, mem_r_en_r, mem_w_en_r, b_r, s_r, move_r, valid_r;
  logic [3:0]       exe_cmd_r;
  logic [WIDTH-1:0] pc_r, val_rn_r, val_rm_r;
  logic             imm_r;
  logic [11:0]      shift_operand_r;
  logic [23:0]      signed_imm_24_r;
  logic [3:0]       dest_r, src1_r, src2_r, sr_r;
  logic [CNT_W-1:0] issued_cnt_r, bubble_cnt_r;

  // Bubble decision, read-wins memory arbitration and saturating counter next values.
  always_comb begin
    bubble_s      = bus.flush | bus.hazard;
    mem_w_en_s    = bus.MEM_W_EN_in & ~bus.MEM_R_EN_in;
    issued_next_s = issued_cnt_r;
    bubble_next_s = bubble_cnt_r;
    if (bubble_s) begin
      if (bubble_cnt_r != CNT_MAX) begin
        bubble_next_s = bubble_cnt_r + CNT_ONE;
      end else begin
        bubble_next_s = bubble_cnt_r;
      end
    end else begin
      if (issued_cnt_r != CNT_MAX) begin
        issued_next_s = issued_cnt_r + CNT_ONE;
      end else begin
        issued_next_s = issued_cnt_r;
      end
    end
  end

  // Pipeline state: reset beats freeze; a frozen edge leaves every register untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_r         <= 1'b0;
      mem_r_en_r      <= 1'b0;
      mem_w_en_r      <= 1'b0;
      b_r             <= 1'b0;
      s_r             <= 1'b0;
      move_r          <= 1'b0;
      valid_r         <= 1'b0;
      exe_cmd_r       <= 4'b0000;
      pc_r            <= {WIDTH{1'b0}};
      val_rn_r        <= {WIDTH{1'b0}};
      val_rm_r        <= {WIDTH{1'b0}};
      imm_r           <= 1'b0;
      shift_operand_r <= 12'h000;
      signed_imm_24_r <= 24'h000000;
      dest_r          <= 4'h0;
      src1_r          <= 4'h0;
      src2_r          <= 4'h0;
      sr_r            <= 4'h0;
      issued_cnt_r    <= {CNT_W{1'b0}};
      bubble_cnt_r    <= {CNT_W{1'b0}};
    end else if (!bus.freeze) begin
      // Data fields load even for bubbles so waveforms stay readable.
      wb_en_r         <= bus.WB_EN_in    & ~bubble_s;
      mem_r_en_r      <= bus.MEM_R_EN_in & ~bubble_s;
      mem_w_en_r      <= mem_w_en_s      & ~bubble_s;
      b_r             <= bus.B_in        & ~bubble_s;
      s_r             <= bus.S_in        & ~bubble_s;
      move_r          <= bus.move_in     & ~bubble_s;
      valid_r         <= ~bubble_s;
      exe_cmd_r       <= bubble_s ? 4'b0000 : bus.EXE_CMD_in;
      pc_r            <= bus.PC_in;
      val_rn_r        <= bus.Val_Rn_in;
      val_rm_r        <= bus.Val_Rm_in;
      imm_r           <= bus.imm_in;
      shift_operand_r <= bus.Shift_operand_in;
      signed_imm_24_r <= bus.Signed_imm_24_in;
      dest_r          <= bus.Dest_in;
      src1_r          <= bus.src1_in;
      src2_r          <= bus.src2_in;
      sr_r            <= bus.SR_in;
      issued_cnt_r    <= issued_next_s;
      bubble_cnt_r    <= bubble_next_s;
    end
  end

  assign bus.WB_EN_out         = wb_en_r;
  assign bus.MEM_R_EN_out      = mem_r_en_r;
  assign bus.MEM_W_EN_out      = mem_w_en_r;
  assign bus.B_out             = b_r;
  assign bus.S_out             = s_r;
  assign bus.move_out          = move_r;
  assign bus.EXE_CMD_out       = exe_cmd_r;
  assign bus.PC_out            = pc_r;
  assign bus.Val_Rn_out        = val_rn_r;
  assign bus.Val_Rm_out        = val_rm_r;
  assign bus.imm_out           = imm_r;
  assign bus.Shift_operand_out = shift_operand_r;
  assign bus.Signed_imm_24_out = signed_imm_24_r;
  assign bus.Dest_out          = dest_r;
  assign bus.src1_out          = src1_r;
  assign bus.src2_out          = src2_r;
  assign bus.SR_out            = sr_r;
  assign bus.valid_out         = valid_r;
  assign bus.issued_cnt        = issued_cnt_r;
  assign bus.bubble_cnt        = bubble_cnt_r;
endmodule
